// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - issue/result bundle between the EX stage and the multiply/divide unit
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, in1, in2, input busy, hi, lo);
  modport slave  (input start, md_op, in1, in2, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - fixed-latency MULT/DIV unit with HI/LO registers for the P6 EX stage
// Optional MADD/MADDU accumulate ops on md_op 110/111 are built when MD_UNIT_MADD_EN is defined.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   md
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic        wr_q, wr_d;

  logic [63:0] prod_s, prod_u;
  logic        div_zero;
  logic [31:0] a_abs, b_abs, q_abs, r_abs, qs, rs, qu, ru;

  assign prod_s = {{32{md.in1[31]}}, md.in1} * {{32{md.in2[31]}}, md.in2};
  assign prod_u = {32'd0, md.in1} * {32'd0, md.in2};

  // Signed divide via magnitudes: quotient sign is the XOR of operand signs,
  // remainder follows the dividend. 0x80000000 / -1 wraps back to 0x80000000.
  assign div_zero = (md.in2 == 32'd0);
  assign a_abs    = md.in1[31] ? -md.in1 : md.in1;
  assign b_abs    = md.in2[31] ? -md.in2 : md.in2;
  assign q_abs    = div_zero ? 32'd0 : a_abs / b_abs;
  assign r_abs    = div_zero ? 32'd0 : a_abs % b_abs;
  assign qs       = (md.in1[31] ^ md.in2[31]) ? -q_abs : q_abs;
  assign rs       = md.in1[31] ? -r_abs : r_abs;
  assign qu       = div_zero ? 32'd0 : md.in1 / md.in2;
  assign ru       = div_zero ? 32'd0 : md.in1 % md.in2;

`ifdef MD_UNIT_MADD_EN
  logic [63:0] madd_s, madd_u;
  assign madd_s = {hi_q, lo_q} + prod_s;
  assign madd_u = {hi_q, lo_q} + prod_u;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    wr_d     = wr_q;
    case (state_q)
      IDLE: begin
        if (md.start) begin
          case (md.md_op)
            3'b000: begin
              {res_hi_d, res_lo_d} = prod_s;
              wr_d = 1'b1; cnt_d = MULT_N; state_d = RUN;
            end
            3'b001: begin
              {res_hi_d, res_lo_d} = prod_u;
              wr_d = 1'b1; cnt_d = MULT_N; state_d = RUN;
            end
            3'b010: begin
              res_hi_d = rs; res_lo_d = qs;
              wr_d = !div_zero; cnt_d = DIV_N; state_d = RUN;
            end
            3'b011: begin
              res_hi_d = ru; res_lo_d = qu;
              wr_d = !div_zero; cnt_d = DIV_N; state_d = RUN;
            end
            3'b100: hi_d = md.in1;
            3'b101: lo_d = md.in1;
`ifdef MD_UNIT_MADD_EN
            3'b110: begin
              {res_hi_d, res_lo_d} = madd_s;
              wr_d = 1'b1; cnt_d = MULT_N; state_d = RUN;
            end
            3'b111: begin
              {res_hi_d, res_lo_d} = madd_u;
              wr_d = 1'b1; cnt_d = MULT_N; state_d = RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        // start is ignored here; the op retires on the 1->0 counter edge
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          if (wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      wr_q     <= wr_d;
    end
  end

  assign md.busy = (state_q == RUN);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the P6 pipelined MIPS core, beside the integer ALU.
- Takes the same forwarded operand pair as the ALU.
- Runs MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency; holds the HI/LO architectural registers and handles MTHI/MTLO.
- Exposes busy so hazard logic stalls MD-class instructions in ID while an operation is in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk)
start  input  1  issue strobe; one cycle per MD instruction in EX
md_op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
in1  input  32  operand rs (dividend / MT source)
in2  input  32  operand rt (divisor)
busy  output  1  operation in flight
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset: the cycle after an edge with reset=0, busy=0, hi=0, lo=0, counter=0, any in-flight op discarded. Reset has priority over start.
- Registered state: hi, lo, busy, a 4-bit down-counter, and latched 64-bit pending result {res_hi,res_lo}.
- FSM states:
  - IDLE (busy=0).
  - RUN (busy=1, counter>0).
- IDLE, start=1, md_op in 000..011, at edge T0:
  - Operands are consumed at T0; later in1/in2 changes have no effect.
  - Result computed from in1/in2 and latched.
  - counter loads MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy reads 1 from T0 to T0+N, i.e. exactly N cycles.
- RUN: counter decrements each edge. On the edge where counter goes 1->0: hi/lo take the pending result, busy falls, state returns to IDLE. hi/lo stay at their old values throughout RUN.
- MTHI/MTLO (start=1, md_op 100/101) in IDLE: hi (resp. lo) <= in1 at that edge. busy never asserts; the other register is unchanged.
- start=1 while busy=1: ignored entirely, no state change. Hazard logic guarantees this never happens legally; the bench must still check it.
- Reserved md_op with start=1: no effect.
- Back-to-back: start may assert on the same edge where busy falls. That edge completes the old op and the same edge must not accept the new start, because busy was 1 when sampled. Acceptance is on the next edge.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi = upper 32 bits, lo = lower 32 bits.
  - MULTU: unsigned 32x32 -> 64.
  - DIV: signed; quotient truncated toward zero -> lo; remainder takes the sign of the dividend -> hi.
  - DIVU: unsigned quotient -> lo, remainder -> hi.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
  - Divisor 0 (DIV or DIVU): full DIV_CYCLES busy, then hi/lo left unchanged.
- Reads: hi/lo are plain register outputs. Forwarding for MFHI/MFLO is outside this block.

Optional Feature:
- Macro: MD_UNIT_MADD_EN.
- Defined: md_op 110 = MADD, 111 = MADDU.
  - MADD: {hi,lo} <= {hi,lo} + signed(in1*in2), 64-bit wrap.
  - MADDU: same with unsigned product.
  - Latency MULT_CYCLES. The addend {hi,lo} is sampled at the accepting edge.
- Undefined: 110/111 are reserved (no effect), and the RTL carries no accumulate adder.

Test Plan:
- Reset, then MULT 0xFFFFFFFE x 0x00000003 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001. Changing in1/in2 during busy does not alter the result.
- DIV 0xFFFFFFF9 (-7) / 0x00000002 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 0x00000007 / 0x00000002 -> lo=3, hi=1.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 -> hi/lo updated the edge after each start, busy stays 0. Then DIV by 0 -> busy 10 cycles, hi/lo unchanged.
- Start DIV, assert start again with MULT at cycle 3, then reset=0 at cycle 6 -> second start ignored; after reset busy=0, hi=lo=0. Then MULT 2x3 -> lo=6 after 5 cycles.
- Edge cases:
  - Start asserted on the completion edge -> not accepted until the next edge.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - With MD_UNIT_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1x1 -> hi=1, lo=0.
